pipe_hazard_ctrl: RTL and testbench

- Central sequencing unit for the five-stage pipeline.
- Generates enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers, including the ID/EX control-bit flops (reg_wr, rd_en, wr_en, wb_sel).
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Raises a sticky fault when the data memory fails to respond.

---
 rtl/pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencing unit for the five-stage pipeline. It generates the
// enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM
// pipeline registers. It resolves load-use hazards, taken-branch flushes and
// multi-cycle data-memory waits, and it raises a sticky fault when the data
// memory stops responding.
//
// Optional feature macro: HAZ_PERF_EN
//   defined   -> stall_cnt counts the cycles with pc_en==0, saturating at 16'hFFFF
//   undefined -> stall_cnt is tied to zero and the counter is not built
//
// Parameters:
//   REG_AW      register-index width
//   MEM_TIMEOUT maximum number of consecutive pending cycles before a fault (>=2)
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   de_rs1, de_rs2       source register indices of the instruction in ID
//   ex_rd, ex_rd_en      destination of the instruction in EX; ex_rd_en marks a load
//   br_taken             EX resolved a taken branch or jump
//   mem_req, mem_ack     MEM-stage access request and its completion
//   pc_en, fd_en,
//   de_en, em_en         enables for the PC and the pipeline registers
//   fd_flush, de_flush   load a NOP into IF/ID; clear the ID/EX control bits
//   mem_err              sticky memory-timeout fault
//   stall_cnt            saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_en,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              fd_en,
    output logic              de_en,
    output logic              em_en,
    output logic              fd_flush,
    output logic              de_flush,
    output logic              mem_err,
    output logic [15:0]       stall_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WCW-1:0]   wait_cnt;
    logic [WCW-1:0]   wait_cnt_nxt;
    logic             frozen;
    logic             load_use;

    // State register and pending-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= {WCW{1'b0}};
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state and pending-cycle counter logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                // A request acked in its first cycle is a single-cycle access.
                if (mem_req && !mem_ack) begin
                    state_nxt    = ST_MEMWAIT;
                    wait_cnt_nxt = WCW'(1);
                end else begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = {WCW{1'b0}};
                end
            end
            ST_MEMWAIT: begin
                if (mem_ack) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = {WCW{1'b0}};
                end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                    // Last allowed pending cycle expired without an ack.
                    state_nxt    = ST_FAULT;
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end else begin
                    state_nxt    = ST_MEMWAIT;
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end
            end
            ST_FAULT: begin
                // Only reset leaves the fault state.
                state_nxt    = ST_FAULT;
                wait_cnt_nxt = wait_cnt;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = {WCW{1'b0}};
            end
        endcase
    end

    // Freeze and load-use hazard detection
    always_comb begin
        frozen   = ((state == ST_RUN) && mem_req && !mem_ack) ||
                   ((state == ST_MEMWAIT) && !mem_ack) ||
                   (state == ST_FAULT);
        load_use = ex_rd_en && (ex_rd != {REG_AW{1'b0}}) &&
                   ((ex_rd == de_rs1) || (ex_rd == de_rs2));
    end

    // Enable and flush outputs, same-cycle response to the inputs
    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        if (reset) begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            de_en    = 1'b1;
            em_en    = 1'b1;
            fd_flush = 1'b0;
            de_flush = 1'b0;
        end else if (frozen) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            fd_flush = 1'b0;
            de_flush = 1'b0;
        end else if (br_taken) begin
            // The branch flushes the dependent instruction, so no stall is needed.
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID for one cycle and let the load move on to MEM,
            // feeding a bubble into ID/EX behind it.
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
        end
    end

    // The fault flag is a direct decode of the state register
    always_comb begin
        mem_err = (state == ST_FAULT);
    end

`ifdef HAZ_PERF_EN
    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. A behavioural model, which tracks the
// number of pending memory cycles and a fault flag, predicts every output on
// every falling edge. Literal checks inside the directed sequence fix the
// key cycles of each scenario.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int TO = 15;

    logic          clk;
    logic          reset;
    logic [AW-1:0] de_rs1;
    logic [AW-1:0] de_rs2;
    logic [AW-1:0] ex_rd;
    logic          ex_rd_en;
    logic          br_taken;
    logic          mem_req;
    logic          mem_ack;
    logic          pc_en;
    logic          fd_en;
    logic          de_en;
    logic          em_en;
    logic          fd_flush;
    logic          de_flush;
    logic          mem_err;
    logic [15:0]   stall_cnt;

    int checks = 0;
    int passes = 0;

`ifdef HAZ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
        .fd_flush(fd_flush), .de_flush(de_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int          pend = 0;      // consecutive unacked cycles of the current request
    bit          faulted = 1'b0;
    int          stalls = 0;

    always @(negedge clk) begin
        logic [6:0] exp_v;
        logic [6:0] act_v;
        bit         frz;
        bit         lu;
        act_v = {pc_en, fd_en, de_en, em_en, fd_flush, de_flush, mem_err};
        if (reset) begin
            pend    = 0;
            faulted = 1'b0;
            stalls  = 0;
            exp_v   = 7'b1111_00_0;
            chk("model_outputs", {9'd0, act_v}, {9'd0, exp_v});
            chk("model_stall_cnt", stall_cnt, 16'd0);
        end else begin
            frz = faulted || (!mem_ack && (mem_req || pend > 0));
            lu  = ex_rd_en && (ex_rd != 0) && (ex_rd == de_rs1 || ex_rd == de_rs2);
            if (frz)           exp_v = {4'b0000, 2'b00, faulted};
            else if (br_taken) exp_v = {4'b1111, 2'b11, 1'b0};
            else if (lu)       exp_v = {4'b0011, 2'b01, 1'b0};
            else               exp_v = {4'b1111, 2'b00, 1'b0};
            chk("model_outputs", {9'd0, act_v}, {9'd0, exp_v});
            chk("model_stall_cnt", stall_cnt, PERF ? 16'(stalls) : 16'd0);
            // advance the model across the coming rising edge
            if (!exp_v[6] && stalls < 65535) stalls++;
            if (!faulted) begin
                if (frz) begin
                    pend++;
                    if (pend == TO) faulted = 1'b1;
                end else begin
                    pend = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic setin(input int rs1, input int rs2, input int rd, input bit rden,
                         input bit br, input bit req, input bit ack);
        de_rs1   = AW'(rs1);
        de_rs2   = AW'(rs2);
        ex_rd    = AW'(rd);
        ex_rd_en = rden;
        br_taken = br;
        mem_req  = req;
        mem_ack  = ack;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        setin(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        chk("rst_pc_en", {15'd0, pc_en}, 16'd1);
        chk("rst_fd_flush", {15'd0, fd_flush}, 16'd0);
        chk("rst_mem_err", {15'd0, mem_err}, 16'd0);
        chk("rst_stall_cnt", stall_cnt, 16'd0);

        // Load-use on rs2: one bubble
        nxt(); reset = 1'b0; setin(1, 5, 5, 1, 0, 0, 0);
        @(negedge clk);
        chk("lu_pc_en", {15'd0, pc_en}, 16'd0);
        chk("lu_fd_en", {15'd0, fd_en}, 16'd0);
        chk("lu_de_flush", {15'd0, de_flush}, 16'd1);
        chk("lu_em_en", {15'd0, em_en}, 16'd1);
        nxt(); setin(1, 5, 5, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_after_pc_en", {15'd0, pc_en}, 16'd1);
        chk("lu_after_de_flush", {15'd0, de_flush}, 16'd0);

        // ex_rd = x0 never stalls
        nxt(); setin(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("x0_pc_en", {15'd0, pc_en}, 16'd1);

        // Branch together with a load-use: branch wins
        nxt(); setin(1, 5, 5, 1, 1, 0, 0);
        @(negedge clk);
        chk("br_flushes", {14'd0, fd_flush, de_flush}, 16'd3);
        chk("br_pc_fd_en", {14'd0, pc_en, fd_en}, 16'd3);

        // Reset pulse to restart the stall count
        nxt(); reset = 1'b1; setin(0, 0, 0, 0, 0, 0, 0);
        nxt(); reset = 1'b0;

        // Memory wait acked in cycle 4, with a load-use hidden in the freeze
        for (int i = 1; i <= 3; i++) begin
            setin(1, 5, 5, 1, 0, 1, 0);
            @(negedge clk);
            chk("mw_frozen_pc_en", {15'd0, pc_en}, 16'd0);
            chk("mw_frozen_de_flush", {15'd0, de_flush}, 16'd0);
            nxt();
        end
        setin(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("mw_ack_en", {12'd0, pc_en, fd_en, de_en, em_en}, 16'hF);
        nxt(); setin(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mw_after_pc_en", {15'd0, pc_en}, 16'd1);
        chk("mw_stall_cnt", stall_cnt, PERF ? 16'd3 : 16'd0);

        // Ack in the last pending cycle prevents the fault
        for (int i = 1; i <= TO - 1; i++) begin
            nxt(); setin(0, 0, 0, 0, 0, 1, 0);
        end
        nxt(); setin(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("late_ack_pc_en", {15'd0, pc_en}, 16'd1);
        nxt(); setin(0, 0, 0, 0, 0, 1, 1);   // single-cycle access in RUN
        @(negedge clk);
        chk("late_ack_mem_err", {15'd0, mem_err}, 16'd0);
        chk("single_cycle_pc_en", {15'd0, pc_en}, 16'd1);

        // Reset asserted in MEMWAIT cycle 4
        for (int i = 1; i <= 3; i++) begin
            nxt(); setin(0, 0, 0, 0, 0, 1, 0);
        end
        nxt(); reset = 1'b1;
        @(negedge clk);
        chk("rw_pc_en", {15'd0, pc_en}, 16'd1);
        chk("rw_stall_cnt", stall_cnt, 16'd0);
        nxt(); reset = 1'b0; setin(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rw_after_en", {12'd0, pc_en, fd_en, de_en, em_en}, 16'hF);
        chk("rw_after_mem_err", {15'd0, mem_err}, 16'd0);

        // Timeout: 15 frozen cycles, fault from cycle 16, held thereafter
        for (int i = 1; i <= TO; i++) begin
            nxt(); setin(0, 0, 0, 0, 0, 1, 0);
        end
        @(negedge clk);
        chk("to_last_pc_en", {15'd0, pc_en}, 16'd0);
        chk("to_last_mem_err", {15'd0, mem_err}, 16'd0);
        nxt(); setin(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("to_fault_mem_err", {15'd0, mem_err}, 16'd1);
        chk("to_fault_pc_en", {15'd0, pc_en}, 16'd0);
        for (int i = 0; i < 70000; i++) begin
            nxt();
        end
        @(negedge clk);
        chk("to_hold_mem_err", {15'd0, mem_err}, 16'd1);
        chk("sat_stall_cnt", stall_cnt, PERF ? 16'hFFFF : 16'd0);

        nxt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
